// File: rtl/serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// serial_pattern_gen
//
// Programmable serial stimulus source. A parallel pattern is accepted through
// a valid/ready handshake and shifted out MSB-first (bit [len-1] first) on a
// single line. Each bit is held for HOLD clocks. The pattern can loop
// continuously, and it can be aborted early with stop.
//
// Parameters:
//   WIDTH       maximum pattern length in bits (>= 1)
//   HOLD        clock cycles each bit is held on out_a (>= 1)
//   IDLE_LEVEL  level driven on out_a when no pattern data is being sent
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset_n    in   asynchronous active-low reset
//   pat_data   in   pattern; bit [pat_len-1] is sent first
//   pat_len    in   number of bits to send (values above WIDTH are clamped)
//   pat_valid  in   pattern offered
//   pat_ready  out  high in IDLE; a pattern is accepted on valid && ready
//   repeat_en  in   loop the pattern at the end of a pass
//   stop       in   abort the current pattern (only acted on while shifting)
//   out_a      out  serial bit, registered
//   out_valid  out  out_a carries pattern data
//   done       out  one-cycle pulse when a pattern finishes or is aborted
//   bit_idx    out  index of the bit being driven (0 = first bit sent)
// ---------------------------------------------------------------------------
module serial_pattern_gen #(
    parameter int   WIDTH      = 8,
    parameter int   HOLD       = 3,
    parameter logic IDLE_LEVEL = 1'b1,
    localparam int  LEN_W      = $clog2(WIDTH + 1),
    localparam int  IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             out_a,
    output logic             out_valid,
    output logic             done,
    output logic [IDX_W-1:0] bit_idx
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] len_q;
    logic [HC_W-1:0]  hold_cnt;

    logic [LEN_W-1:0] len_in;
    logic [WIDTH-1:0] first_shift;   // incoming pattern aligned to its first bit
    logic [WIDTH-1:0] next_shift;    // stored pattern aligned to the following bit
    logic [WIDTH-1:0] restart_shift; // stored pattern aligned to its first bit
    logic             last_hold;
    logic             last_bit;
    logic             finish_pass;

    // Bits are picked by shifting the word down and taking bit 0, which keeps
    // the select width independent of the length counter width.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        len_in        = (pat_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : pat_len;
        first_shift   = pat_data >> (len_in - LEN_W'(1));
        next_shift    = data_q >> (len_q - LEN_W'(2) - LEN_W'(bit_idx));
        restart_shift = data_q >> (len_q - LEN_W'(1));
        last_hold     = (hold_cnt == HC_W'(HOLD - 1));
        last_bit      = (LEN_W'(bit_idx) == len_q - LEN_W'(1));
        // Leave SHIFT on an abort, or at the end of a pass that does not loop.
        finish_pass   = (state == S_SHIFT) &&
                        (stop || (last_hold && last_bit && !repeat_en));
    end

    assign pat_ready = (state == S_IDLE);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the clock edge, independent of the
    // order of the statements.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            data_q    <= '0;
            len_q     <= '0;
            hold_cnt  <= '0;
            bit_idx   <= '0;
            out_a     <= IDLE_LEVEL;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pat_valid) begin
                        data_q   <= pat_data;
                        len_q    <= len_in;
                        bit_idx  <= '0;
                        hold_cnt <= '0;
                        if (len_in == '0) begin
                            // Empty pattern: report completion without data.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_SHIFT;
                            out_valid <= 1'b1;
                            out_a     <= first_shift[0];
                        end
                    end
                end

                S_SHIFT: begin
                    if (finish_pass) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        out_valid <= 1'b0;
                        out_a     <= IDLE_LEVEL;
                        bit_idx   <= '0;
                        hold_cnt  <= '0;
                    end else if (last_hold) begin
                        hold_cnt <= '0;
                        if (!last_bit) begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            out_a   <= next_shift[0];
                        end else begin
                            // Looping: start the next pass with no idle gap.
                            bit_idx <= '0;
                            out_a   <= restart_shift[0];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_gen
//
// Self-checking bench for serial_pattern_gen (WIDTH=8, HOLD=3, IDLE_LEVEL=1).
// Each accepted pattern pushes its expected serial stream (one entry per
// clock: bit value and bit index) into a queue; a monitor on the falling
// edge pops one entry for every out_valid cycle and compares.
// ---------------------------------------------------------------------------
module tb_serial_pattern_gen;

    localparam int WIDTH = 8;
    localparam int HOLD  = 3;
    localparam int LEN_W = 4;
    localparam int IDX_W = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] pat_data = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             pat_valid = 1'b0;
    logic             pat_ready;
    logic             repeat_en = 1'b0;
    logic             stop = 1'b0;
    logic             out_a;
    logic             out_valid;
    logic             done;
    logic [IDX_W-1:0] bit_idx;

    always #5 clock = ~clock;

    serial_pattern_gen #(
        .WIDTH      (WIDTH),
        .HOLD       (HOLD),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .repeat_en (repeat_en),
        .stop      (stop),
        .out_a     (out_a),
        .out_valid (out_valid),
        .done      (done),
        .bit_idx   (bit_idx)
    );

    typedef struct {
        logic bit_v;
        int   idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   acc_cyc   = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;
    logic prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_done = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", out_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_a", out_a, mon_e.bit_v);
                    check("bit_idx", bit_idx, mon_e.idx);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_width", prev_done, 1'b0);
                check("done_out_valid", out_valid, 1'b0);
                check("done_out_a", out_a, 1'b1);
                check("done_bit_idx", bit_idx, 0);
                check("done_pat_ready", pat_ready, 1'b0);
            end
            prev_done = done;
        end
    end

    // Offer a pattern while idle, push the expected stream for `passes`
    // passes, and scramble the inputs right after acceptance.
    task automatic send(input logic [7:0] d, input int len, input logic rep, input int passes);
        int n;
        n = (len > WIDTH) ? WIDTH : len;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < n; i++)
                for (int h = 0; h < HOLD; h++)
                    sb.push_back('{bit_v: d[n-1-i], idx: i});
        pat_data  = d;
        pat_len   = LEN_W'(len);
        repeat_en = rep;
        pat_valid = 1'b1;
        @(posedge clock);
        #1;
        acc_cyc   = cyc;
        pat_valid = 1'b0;
        pat_data  = 8'($urandom);
        pat_len   = LEN_W'($urandom_range(0, 15));
        exp_done++;
    endtask

    // Wait (bounded) for pat_ready, then check scoreboard drain and done count.
    task automatic wait_idle(input string tag);
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (pat_ready) break;
        end
        check({tag, "_ready"}, pat_ready, 1'b1);
        check({tag, "_sb_left"}, sb.size(), 0);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
    endtask

    // Same as wait_idle, plus ready latency: ready returns len*HOLD+1 cycles
    // after the accepting edge, so the next accept is len*HOLD+2 later.
    task automatic wait_idle_lat(input string tag, input int len, input int passes);
        int n;
        n = (len > WIDTH) ? WIDTH : len;
        wait_idle(tag);
        check({tag, "_ready_lat"}, cyc - acc_cyc, n * HOLD * passes + 1);
    endtask

    // Wait (bounded) until a given bit index is being driven.
    task automatic wait_idx(input string tag, input int idx);
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (out_valid && bit_idx == IDX_W'(idx)) break;
        end
        check(tag, bit_idx, idx);
    endtask

    initial begin
        // Reset held for 3 cycles.
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("rst_out_a", out_a, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bit_idx", bit_idx, 0);
        check("rst_pat_ready", pat_ready, 1'b1);

        // Single full-length pass.
        send(8'b1011_0010, 8, 1'b0, 1);
        wait_idle_lat("single", 8, 1);

        // Short pattern: bits 1,0,1.
        send(8'b0000_0101, 3, 1'b0, 1);
        wait_idle_lat("len3", 3, 1);

        // Length above WIDTH is clamped to 8.
        send(8'b0110_1001, 12, 1'b0, 1);
        wait_idle_lat("len12", 12, 1);

        // Zero length: done on the next cycle, never valid.
        send(8'hFF, 0, 1'b0, 1);
        @(negedge clock);
        check("len0_done", done, 1'b1);
        check("len0_out_valid", out_valid, 1'b0);
        wait_idle_lat("len0", 0, 1);

        // Repeat: drop repeat_en during bit 0 of pass 3 -> three passes.
        send(8'b0000_0010, 2, 1'b1, 3);
        repeat (13) @(posedge clock);
        #1 repeat_en = 1'b0;
        wait_idle_lat("repeat", 2, 3);

        // pat_valid during SHIFT is ignored and does not disturb the stream.
        send(8'b1100_0101, 8, 1'b0, 1);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            pat_valid = 1'b1;
            pat_data  = 8'($urandom);
            pat_len   = LEN_W'(8);
            check("shift_pat_ready", pat_ready, 1'b0);
            @(negedge clock);
        end
        pat_valid = 1'b0;
        wait_idle_lat("valid_in_shift", 8, 1);

        // Abort at bit_idx 2.
        send(8'b1110_0101, 8, 1'b0, 1);
        wait_idx("abort_reach_idx2", 2);
        stop = 1'b1;
        @(posedge clock);
        #1 stop = 1'b0;
        sb.delete();
        @(negedge clock);
        check("abort_done", done, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_a", out_a, 1'b1);
        wait_idle("abort");

        // Asynchronous reset mid-shift at bit_idx 4.
        send(8'b1011_0010, 8, 1'b0, 1);
        wait_idx("rst_reach_idx4", 4);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_a", out_a, 1'b1);
        check("arst_done", done, 1'b0);
        check("arst_bit_idx", bit_idx, 0);
        check("arst_pat_ready", pat_ready, 1'b1);
        sb.delete();
        exp_done--;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("arst_no_done", done_cnt, exp_done);

        // Clean restart after reset.
        send(8'b0000_0110, 3, 1'b0, 1);
        wait_idle_lat("post_reset", 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
